// File: rtl/qspi_target.sv
// Quad-SPI memory responder: stands in for external flash/PSRAM on the SoC's QSPI initiator.
// Backs a byte-wide internal memory that a host-side load port can preload and inspect while idle.
module qspi_target #(
  parameter int         MEM_BYTES = 256,
  parameter int         DUMMY     = 4,
  parameter logic [7:0] CMD_READ  = 8'hEB,
  parameter logic [7:0] CMD_WRITE = 8'h38
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cs_n,
  input  logic [3:0]                   sio_in,
  output logic [3:0]                   sio_out,
  output logic [3:0]                   sio_oe,
  input  logic                         load_we,
  input  logic [$clog2(MEM_BYTES)-1:0] load_addr,
  input  logic [7:0]                   load_wdata,
  output logic [7:0]                   load_rdata,
  output logic                         load_ack,
  output logic                         busy,
  output logic [7:0]                   bad_cmd
);

  localparam int AW = $clog2(MEM_BYTES);
  localparam logic [7:0] DUMMY_LAST = 8'((DUMMY > 0) ? DUMMY - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DUMMY,
    S_RDATA,
    S_WDATA,
    S_IGNORE
  } state_t;

  state_t state_q, state_d;

  logic [7:0]    mem [MEM_BYTES];
  logic [3:0]    op_hi;
  logic [3:0]    wr_hi;
  logic [7:0]    opcode;
  logic          is_read;
  logic          known_op;
  logic [AW-1:0] ptr;
  logic [7:0]    cnt;
  logic          phase;
  logic          hold_off;
  logic          wr_fire;
  logic          load_fire;

  assign opcode    = {op_hi, sio_in};
  assign known_op  = (opcode == CMD_READ) || (opcode == CMD_WRITE);
  assign busy      = (state_q != S_IDLE);
  assign wr_fire   = (state_q == S_WDATA) && !cs_n && phase;
  assign load_fire = load_we && (state_q == S_IDLE) && cs_n;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // hold_off remembers that reset was released mid-frame, so the rest of that frame is ignored.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (!cs_n) state_d = hold_off ? S_IGNORE : S_CMD;
      S_CMD:   state_d = known_op ? S_ADDR : S_IGNORE;
      S_ADDR:  if (cnt == 8'd5) begin
                 if (!is_read)        state_d = S_WDATA;
                 else if (DUMMY == 0) state_d = S_RDATA;
                 else                 state_d = S_DUMMY;
               end
      S_DUMMY: if (cnt == DUMMY_LAST) state_d = S_RDATA;
      default: ;
    endcase
    if (cs_n) state_d = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sio_out    <= '0;
      sio_oe     <= '0;
      load_rdata <= '0;
      load_ack   <= 1'b0;
      bad_cmd    <= '0;
      hold_off   <= ~cs_n;
      op_hi      <= '0;
      wr_hi      <= '0;
      is_read    <= 1'b0;
      ptr        <= '0;
      cnt        <= '0;
      phase      <= 1'b0;
    end else begin
      load_ack   <= load_fire;
      load_rdata <= mem[load_addr];
      sio_oe     <= '0;
      if (cs_n) hold_off <= 1'b0;
      cnt   <= (state_d != state_q) ? '0 : cnt + 8'd1;
      phase <= ((state_q == S_RDATA) || (state_q == S_WDATA)) ? ~phase : 1'b0;

      if (!cs_n) begin
        unique case (state_q)
          S_IDLE: op_hi <= sio_in;
          S_CMD: begin
            is_read <= (opcode == CMD_READ);
            if (!known_op && (bad_cmd != 8'hFF)) bad_cmd <= bad_cmd + 8'd1;
          end
          S_ADDR: ptr <= AW'({ptr, sio_in});
          S_RDATA: begin
            sio_oe  <= '1;
            sio_out <= phase ? mem[ptr][3:0] : mem[ptr][7:4];
            if (phase) ptr <= ptr + AW'(1);
          end
          S_WDATA: begin
            if (!phase) wr_hi <= sio_in;
            else        ptr   <= ptr + AW'(1);
          end
          default: ;
        endcase
      end
    end
  end

  // Bus writes and load writes are mutually exclusive by state; reset blocks both.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (wr_fire)        mem[ptr]       <= {wr_hi, sio_in};
      else if (load_fire) mem[load_addr] <= load_wdata;
    end
  end

endmodule

// File: tb/tb_qspi_target.sv
// Self-checking bench for qspi_target: randomized QSPI traffic against a byte-array memory model.
module tb_qspi_target;

  localparam int MEM_BYTES = 256;
  localparam int DUMMY     = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       cs_n;
  logic [3:0] sio_in;
  logic [3:0] sio_out;
  logic [3:0] sio_oe;
  logic       load_we;
  logic [7:0] load_addr;
  logic [7:0] load_wdata;
  logic [7:0] load_rdata;
  logic       load_ack;
  logic       busy;
  logic [7:0] bad_cmd;

  int checks = 0;
  int errors = 0;
  logic [7:0] ref_mem [MEM_BYTES];
  int ref_bad = 0;
  logic [7:0] wbuf [8];

  qspi_target #(
    .MEM_BYTES(MEM_BYTES),
    .DUMMY    (DUMMY),
    .CMD_READ (8'hEB),
    .CMD_WRITE(8'h38)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cs_n      (cs_n),
    .sio_in    (sio_in),
    .sio_out   (sio_out),
    .sio_oe    (sio_oe),
    .load_we   (load_we),
    .load_addr (load_addr),
    .load_wdata(load_wdata),
    .load_rdata(load_rdata),
    .load_ack  (load_ack),
    .busy      (busy),
    .bad_cmd   (bad_cmd)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_nib(input logic [3:0] n);
    cs_n   = 1'b0;
    sio_in = n;
    tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_nib(b[7:4]);
    send_nib(b[3:0]);
  endtask

  task automatic end_txn;
    cs_n   = 1'b1;
    sio_in = 4'($urandom);
    tick();
  endtask

  task automatic send_header(input logic [7:0] op, input int addr);
    logic [23:0] a24;
    a24      = 24'($urandom);
    a24[7:0] = 8'(addr);
    send_byte(op);
    send_byte(a24[23:16]);
    send_byte(a24[15:8]);
    send_byte(a24[7:0]);
  endtask

  // Read nnib nibbles starting at addr; expected data comes from the byte-array model.
  task automatic do_read(input int addr, input int nnib, input string tag);
    logic [7:0] b;
    logic [3:0] exp_n;
    send_header(8'hEB, addr);
    checks++;
    if (sio_oe !== 4'h0) begin
      errors++;
      $display("FAIL %s oe_after_addr got %h want 0", tag, sio_oe);
    end
    for (int i = 0; i < DUMMY; i++) begin
      send_nib(4'($urandom));
      checks++;
      if (sio_oe !== 4'h0) begin
        errors++;
        $display("FAIL %s oe_dummy%0d got %h want 0", tag, i, sio_oe);
      end
    end
    for (int i = 0; i < nnib; i++) begin
      send_nib(4'($urandom));
      b     = ref_mem[(addr + i / 2) % MEM_BYTES];
      exp_n = (i % 2 == 0) ? b[7:4] : b[3:0];
      checks++;
      if (sio_oe !== 4'hF || sio_out !== exp_n) begin
        errors++;
        $display("FAIL %s nib%0d got oe=%h out=%h want oe=f out=%h", tag, i, sio_oe, sio_out, exp_n);
      end
    end
    end_txn();
    checks++;
    if (sio_oe !== 4'h0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s end got oe=%h busy=%b want oe=0 busy=0", tag, sio_oe, busy);
    end
  endtask

  // Write nbytes full bytes, optionally followed by a lone high nibble that must be discarded.
  task automatic do_write(input int addr, input logic [7:0] data [8], input int nbytes,
                          input bit half, input string tag);
    send_header(8'h38, addr);
    for (int i = 0; i < nbytes; i++) begin
      send_nib(data[i][7:4]);
      send_nib(data[i][3:0]);
      checks++;
      if (sio_oe !== 4'h0) begin
        errors++;
        $display("FAIL %s oe_wr%0d got %h want 0", tag, i, sio_oe);
      end
    end
    if (half) send_nib(data[nbytes][7:4]);
    end_txn();
    checks++;
    if (busy !== 1'b0 || sio_oe !== 4'h0) begin
      errors++;
      $display("FAIL %s end got busy=%b oe=%h want busy=0 oe=0", tag, busy, sio_oe);
    end
    for (int i = 0; i < nbytes; i++) ref_mem[(addr + i) % MEM_BYTES] = data[i];
  endtask

  task automatic load_byte(input int addr, input logic [7:0] d, input string tag);
    load_we    = 1'b1;
    load_addr  = 8'(addr);
    load_wdata = d;
    tick();
    load_we = 1'b0;
    checks++;
    if (load_ack !== 1'b1) begin
      errors++;
      $display("FAIL %s ack@%0h got %b want 1", tag, addr, load_ack);
    end
    ref_mem[addr] = d;
  endtask

  task automatic test_reset;
    reset = 1'b1; cs_n = 1'b1; sio_in = '0;
    load_we = 1'b0; load_addr = '0; load_wdata = '0;
    repeat (3) tick();
    checks++;
    if (sio_out !== 4'h0 || sio_oe !== 4'h0 || load_rdata !== 8'h00 || load_ack !== 1'b0 ||
        busy !== 1'b0 || bad_cmd !== 8'h00) begin
      errors++;
      $display("FAIL reset got out=%h oe=%h rdata=%h ack=%b busy=%b bad=%h want all 0",
               sio_out, sio_oe, load_rdata, load_ack, busy, bad_cmd);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || load_ack !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got busy=%b ack=%b want 0 0", busy, load_ack);
    end
  endtask

  task automatic test_load;
    for (int a = 0; a < MEM_BYTES; a++) load_byte(a, 8'($urandom), "preload");
    load_byte(8'h10, 8'hA5, "load10");
    load_byte(8'h11, 8'h3C, "load11");
    tick();
    checks++;
    if (load_ack !== 1'b0) begin
      errors++;
      $display("FAIL ack_idle got %b want 0", load_ack);
    end
    for (int a = 8'h0E; a < 8'h14; a++) begin
      load_addr = 8'(a);
      tick();
      checks++;
      if (load_rdata !== ref_mem[a]) begin
        errors++;
        $display("FAIL load_rd@%0h got %h want %h", a, load_rdata, ref_mem[a]);
      end
    end
  endtask

  task automatic test_read;
    do_read(8'h10, 4, "read10");
  endtask

  task automatic test_write_wrap;
    logic [7:0] exp_b [3];
    exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33;
    wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33;
    do_write(8'hFE, wbuf, 3, 1'b0, "wrap");
    for (int i = 0; i < 3; i++) begin
      load_addr = 8'((8'hFE + i) % MEM_BYTES);
      tick();
      checks++;
      if (load_rdata !== exp_b[i]) begin
        errors++;
        $display("FAIL wrap_mem@%0h got %h want %h", load_addr, load_rdata, exp_b[i]);
      end
    end
  endtask

  task automatic test_write_abort;
    logic [7:0] old41;
    old41 = ref_mem[8'h41];
    wbuf[0] = 8'($urandom);
    wbuf[1] = ~old41;
    do_write(8'h40, wbuf, 1, 1'b1, "abort");
    load_addr = 8'h40;
    tick();
    checks++;
    if (load_rdata !== wbuf[0]) begin
      errors++;
      $display("FAIL abort_b1 got %h want %h", load_rdata, wbuf[0]);
    end
    load_addr = 8'h41;
    tick();
    checks++;
    if (load_rdata !== old41) begin
      errors++;
      $display("FAIL abort_b2 got %h want %h", load_rdata, old41);
    end
  endtask

  task automatic test_bad_cmd;
    logic [7:0] op;
    int oe_seen;
    oe_seen = 0;
    send_byte(8'h9F);
    ref_bad++;
    for (int i = 0; i < 20; i++) begin
      send_nib(4'($urandom));
      if (sio_oe !== 4'h0) oe_seen++;
    end
    end_txn();
    checks++;
    if (oe_seen != 0 || bad_cmd !== 8'(ref_bad)) begin
      errors++;
      $display("FAIL bad_9f got bad=%h oe_cycles=%0d want bad=%h oe_cycles=0", bad_cmd, oe_seen, ref_bad);
    end
    do_read(8'h10, 4, "read_after_bad");
    for (int i = 0; i < 300; i++) begin
      do op = 8'($urandom); while (op == 8'hEB || op == 8'h38);
      send_byte(op);
      end_txn();
      ref_bad++;
    end
    checks++;
    if (bad_cmd !== 8'((ref_bad > 255) ? 255 : ref_bad)) begin
      errors++;
      $display("FAIL bad_sat got %h want ff", bad_cmd);
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] tgt;
    logic [7:0] nibs [5];
    int oe_seen;
    int idle_seen;
    tgt = 8'h55;
    oe_seen = 0;
    idle_seen = 0;
    send_byte(8'h38);
    send_nib(4'h0); send_nib(4'h0); send_nib(4'h0);
    reset = 1'b1;
    send_nib(4'h0);
    reset = 1'b0;
    ref_bad = 0;
    checks++;
    if (busy !== 1'b0 || bad_cmd !== 8'h00 || sio_oe !== 4'h0 || load_rdata !== 8'h00 || load_ack !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got busy=%b bad=%h oe=%h rdata=%h ack=%b want 0", busy, bad_cmd, sio_oe, load_rdata, load_ack);
    end
    // Remaining low cycles look like a complete write to tgt; none of it may land.
    nibs[0] = 8'h38; nibs[1] = 8'h00; nibs[2] = 8'h00; nibs[3] = tgt; nibs[4] = ~ref_mem[tgt];
    for (int i = 0; i < 5; i++) begin
      send_nib(nibs[i][7:4]);
      if (sio_oe !== 4'h0) oe_seen++;
      if (busy !== 1'b1) idle_seen++;
      send_nib(nibs[i][3:0]);
      if (sio_oe !== 4'h0) oe_seen++;
      if (busy !== 1'b1) idle_seen++;
    end
    checks++;
    if (oe_seen != 0 || idle_seen != 0) begin
      errors++;
      $display("FAIL ignore got oe_cycles=%0d not_busy_cycles=%0d want 0 0", oe_seen, idle_seen);
    end
    end_txn();
    load_addr = tgt;
    tick();
    checks++;
    if (load_rdata !== ref_mem[tgt]) begin
      errors++;
      $display("FAIL ignore_mem got %h want %h", load_rdata, ref_mem[tgt]);
    end
    do_read(tgt, 4, "read_after_reset");
  endtask

  task automatic test_load_collision;
    logic [7:0] a;
    a = 8'h10;
    send_header(8'hEB, a);
    for (int i = 0; i < DUMMY; i++) send_nib(4'($urandom));
    load_we    = 1'b1;
    load_addr  = a;
    load_wdata = ~ref_mem[a];
    send_nib(4'($urandom));
    load_we = 1'b0;
    send_nib(4'($urandom));
    checks++;
    if (load_ack !== 1'b0) begin
      errors++;
      $display("FAIL busy_load_ack got %b want 0", load_ack);
    end
    end_txn();
    tick();
    checks++;
    if (load_rdata !== ref_mem[a]) begin
      errors++;
      $display("FAIL busy_load_mem got %h want %h", load_rdata, ref_mem[a]);
    end
    load_byte(a, ~ref_mem[a], "idle_load");
    tick();
    checks++;
    if (load_rdata !== ref_mem[a]) begin
      errors++;
      $display("FAIL idle_load_mem got %h want %h", load_rdata, ref_mem[a]);
    end
  endtask

  task automatic test_back_to_back;
    int a;
    int n;
    bit h;
    for (int t = 0; t < 40; t++) begin
      a = $urandom_range(0, MEM_BYTES - 1);
      if ($urandom_range(0, 1) == 1) begin
        n = $urandom_range(0, 6);
        h = 1'($urandom);
        for (int i = 0; i < 8; i++) wbuf[i] = 8'($urandom);
        do_write(a, wbuf, n, h, "rand_wr");
      end else begin
        do_read(a, $urandom_range(1, 12), "rand_rd");
      end
    end
    for (int i = 0; i < MEM_BYTES; i++) begin
      load_addr = 8'(i);
      tick();
      checks++;
      if (load_rdata !== ref_mem[i]) begin
        errors++;
        $display("FAIL final_mem@%0h got %h want %h", i, load_rdata, ref_mem[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_read();
    test_write_wrap();
    test_write_abort();
    test_bad_cmd();
    test_reset_mid();
    test_load_collision();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
